// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// ---------------
// Consumer side of the hazard stall request for the five-stage MIPS pipeline.
// Turns the hazard unit's stall request and the DE-stage branch decision into
// per-stage enable / flush / bubble controls, sequences interrupt entry
// (drain EX/MA/WB, then vector the PC and write EPC) and keeps a saturating
// count of hazard stall cycles for performance visibility.
//
// Parameters
//   DRAIN_DEPTH : bubble cycles needed to empty EX, MA and WB (1..15)
//   PERF_W      : width of the stall-cycle counter
//
// Ports
//   i_clk          : system clock, rising edge
//   i_rst_n        : asynchronous active-low reset
//   i_stall_en     : stall request from the hazard unit (same cycle)
//   i_branch_taken : branch/jump resolved taken in DE; IF/DE is wrong-path
//   i_irq          : level-sensitive external interrupt request
//   i_eret_wb      : one-cycle pulse when an ERET retires in WB
//   i_cnt_clr      : synchronous clear of the stall counter
//   o_pc_en        : PC register load enable
//   o_ifde_en      : IF/DE register load enable
//   o_ifde_flush   : load a NOP into IF/DE on the next edge
//   o_deex_bubble  : load a NOP into DE/EX on the next edge
//   o_pc_sel_vec   : select the exception vector as next PC
//   o_epc_we       : capture the DE-stage PC into EPC
//   o_irq_ack      : one-cycle pulse on interrupt entry
//   o_in_isr       : registered; handler active, further irq masked
//   o_stall_cnt    : registered; hazard stall cycles seen in RUN

module pipe_stall_ctrl #(
    parameter int unsigned DRAIN_DEPTH = 3,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall_en,
    input  logic              i_branch_taken,
    input  logic              i_irq,
    input  logic              i_eret_wb,
    input  logic              i_cnt_clr,
    output logic              o_pc_en,
    output logic              o_ifde_en,
    output logic              o_ifde_flush,
    output logic              o_deex_bubble,
    output logic              o_pc_sel_vec,
    output logic              o_epc_we,
    output logic              o_irq_ack,
    output logic              o_in_isr,
    output logic [PERF_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        VECTOR = 2'd2
    } state_e;

    // The accept cycle is itself the first bubble, so the drain counter only
    // has to cover the remaining DRAIN_DEPTH-1 cycles.
    localparam logic [3:0]        DRAIN_LOAD = 4'(DRAIN_DEPTH - 1);
    localparam logic [PERF_W-1:0] CNT_MAX    = '1;

    state_e            state_q, state_d;
    logic [3:0]        drainCnt_q, drainCnt_d;
    logic              inIsr_q, inIsr_d;
    logic [PERF_W-1:0] stallCnt_q, stallCnt_d;

    logic irqAccept;
    logic pcEn, ifdeEn, ifdeFlush, deexBubble, pcSelVec, epcWe, irqAck;

    // A taken branch defers the interrupt by one cycle so the branch target
    // reaches DE and becomes the instruction whose PC lands in EPC.
    assign irqAccept = (state_q == RUN) && i_irq && !inIsr_q && !i_branch_taken;

    // Next-state logic for the FSM, drain counter, ISR flag and stall counter.
    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        inIsr_d    = inIsr_q;
        stallCnt_d = stallCnt_q;

        unique case (state_q)
            RUN: begin
                if (irqAccept) begin
                    drainCnt_d = DRAIN_LOAD;
                    state_d    = (DRAIN_DEPTH <= 1) ? VECTOR : DRAIN;
                end
            end
            DRAIN: begin
                // Entry is committed here: a dropped irq does not abort it.
                drainCnt_d = drainCnt_q - 4'd1;
                if (drainCnt_q <= 4'd1) begin
                    state_d = VECTOR;
                end
            end
            VECTOR: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Entering the handler wins over a simultaneous ERET retirement.
        if (state_q == VECTOR) begin
            inIsr_d = 1'b1;
        end else if (i_eret_wb) begin
            inIsr_d = 1'b0;
        end

        // Only genuine hazard stalls in RUN count; interrupt bubbles do not.
        if (i_cnt_clr) begin
            stallCnt_d = '0;
        end else if ((state_q == RUN) && i_stall_en && !irqAccept
                     && (stallCnt_q != CNT_MAX)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    // State registers; reset returns to RUN with the handler inactive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= RUN;
            drainCnt_q <= '0;
            inIsr_q    <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            drainCnt_q <= drainCnt_d;
            inIsr_q    <= inIsr_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // Pipeline controls. These stay combinational so a stall request
    // freezes the front end in the same cycle it is raised.
    always_comb begin
        pcEn       = 1'b0;
        ifdeEn     = 1'b0;
        ifdeFlush  = 1'b0;
        deexBubble = 1'b0;
        pcSelVec   = 1'b0;
        epcWe      = 1'b0;
        irqAck     = 1'b0;

        unique case (state_q)
            RUN: begin
                // A stalled branch has not resolved yet, so it cannot flush.
                ifdeFlush = i_branch_taken && !i_stall_en;
                if (irqAccept) begin
                    // Hold DE so that instruction's PC becomes the EPC.
                    deexBubble = 1'b1;
                end else begin
                    pcEn       = !i_stall_en;
                    ifdeEn     = !i_stall_en;
                    deexBubble = i_stall_en;
                end
            end
            DRAIN: begin
                deexBubble = 1'b1;
            end
            VECTOR: begin
                pcEn       = 1'b1;
                ifdeEn     = 1'b1;
                ifdeFlush  = 1'b1;
                deexBubble = 1'b1;
                pcSelVec   = 1'b1;
                epcWe      = 1'b1;
                irqAck     = 1'b1;
            end
            default: begin
                deexBubble = 1'b1;
            end
        endcase
    end

    // Everything is forced low while reset is asserted, including the enables.
    assign o_pc_en       = i_rst_n & pcEn;
    assign o_ifde_en     = i_rst_n & ifdeEn;
    assign o_ifde_flush  = i_rst_n & ifdeFlush;
    assign o_deex_bubble = i_rst_n & deexBubble;
    assign o_pc_sel_vec  = i_rst_n & pcSelVec;
    assign o_epc_we      = i_rst_n & epcWe;
    assign o_irq_ack     = i_rst_n & irqAck;
    assign o_in_isr      = inIsr_q;
    assign o_stall_cnt   = stallCnt_q;

endmodule
